// File: rtl/fm0_bit_decoder_pkg.sv
// Shared definitions for the FM0 receive bit decoder.
//   state_e            : decoder FSM encoding (IDLE/RUN/DONE)
//   HALF_W             : width of half-symbol counters and per-bank half lengths
//   DEFAULT_HALF_LENS  : packed samples-per-half-symbol, bank i at [i*8 +: 8]
//   fm0_* functions    : FM0 symbol conventions shared with the transmit encoder
package fm0_bit_decoder_pkg;

  localparam int unsigned HALF_W        = 8;
  localparam int unsigned DEFAULT_BANKS = 4;

  localparam logic [DEFAULT_BANKS*HALF_W-1:0] DEFAULT_HALF_LENS =
    {8'd20, 8'd16, 8'd12, 8'd8};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // No mid-symbol inversion encodes data-1, an inversion encodes data-0.
  function automatic logic fm0_data_bit(input logic h1, input logic h2);
    return h1 == h2;
  endfunction

  // Every symbol must start inverted relative to the previous symbol's end.
  function automatic logic fm0_boundary_ok(input logic prev_h2, input logic h1);
    return prev_h2 != h1;
  endfunction

endpackage

// File: rtl/fm0_bit_decoder_half_symbol_integrator.sv
// Majority-vote integrator for one FM0 half-symbol.
//   clk, rst      : clock, synchronous active-high reset
//   clr_i         : clears the sample and ones counters (frame start)
//   en_i          : accept dat_i this cycle
//   dat_i         : oversampled data bit
//   half_len_i    : samples per half-symbol (>= 2)
//   level_c       : majority level including the current sample (ties -> 1)
//   half_close_c  : current accepted sample is the last of a half-symbol
module fm0_bit_decoder_half_symbol_integrator
  import fm0_bit_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              dat_i,
  input  logic [HALF_W-1:0] half_len_i,
  output logic              level_c,
  output logic              half_close_c
);

  logic [HALF_W-1:0] hcnt_q;
  logic [HALF_W-1:0] ones_q;
  logic [HALF_W-1:0] ones_d;
  logic [HALF_W:0]   twice_ones_c;

  // Decision uses the count including the sample being accepted now.
  always_comb begin
    ones_d       = ones_q + HALF_W'(dat_i);
    twice_ones_c = {ones_d, 1'b0};
    level_c      = (twice_ones_c >= {1'b0, half_len_i});
    half_close_c = en_i && (hcnt_q == (half_len_i - HALF_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      hcnt_q <= '0;
      ones_q <= '0;
    end else if (en_i) begin
      if (half_close_c) begin
        hcnt_q <= '0;
        ones_q <= '0;
      end else begin
        hcnt_q <= hcnt_q + HALF_W'(1);
        ones_q <= ones_d;
      end
    end
  end

endmodule

// File: rtl/fm0_bit_decoder.sv
// FM0 bit decoder: integrates half-symbols, emits data bits, ends the frame
// on a missing boundary inversion or when MAX_BITS bits have been emitted.
//   clk, rst           : clock, synchronous active-high reset
//   start              : frame start pulse (restarts an active frame)
//   bank               : frequency bank, sampled with start
//   in_dat, in_vld     : oversampled stream and its strobe
//   out_bit, out_vld   : decoded bit and its one-cycle strobe
//   frame_done         : one-cycle end-of-frame pulse
//   frame_err          : with frame_done, 1 = ended by MAX_BITS cap
//   frame_bits         : bits emitted in the frame, held after frame_done
//   busy               : frame in progress
module fm0_bit_decoder
  import fm0_bit_decoder_pkg::*;
#(
  parameter int unsigned              BANKS     = 4,
  parameter logic [BANKS*HALF_W-1:0]  HALF_LENS = DEFAULT_HALF_LENS,
  parameter int unsigned              MAX_BITS  = 512,
  parameter int unsigned              CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(BANKS)-1:0]   bank,
  input  logic                       in_dat,
  input  logic                       in_vld,
  output logic                       out_bit,
  output logic                       out_vld,
  output logic                       frame_done,
  output logic                       frame_err,
  output logic [CNT_WIDTH-1:0]       frame_bits,
  output logic                       busy
);

  localparam int unsigned          BANK_W  = $clog2(BANKS);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_BITS);

  state_e               state_q;
  logic [HALF_W-1:0]    half_len_q;
  logic [HALF_W-1:0]    bank_len_c;
  logic                 half_q;
  logic                 h1_q;
  logic                 prev_q;
  logic                 first_sym_q;
  logic [CNT_WIDTH-1:0] bits_q;
  logic [CNT_WIDTH-1:0] bits_d;
  logic                 run_c;
  logic                 level_c;
  logic                 half_close_c;

  // Half length of the requested bank.
  always_comb begin
    bank_len_c = '0;
    for (int unsigned i = 0; i < BANKS; i++) begin
      if (bank == BANK_W'(i)) begin
        bank_len_c = HALF_LENS[i*HALF_W +: HALF_W];
      end
    end
  end

  // Samples count only in RUN and not on a restart cycle; bits saturates.
  always_comb begin
    run_c  = (state_q == ST_RUN) && in_vld && !start;
    bits_d = (bits_q == MAX_CNT) ? bits_q : bits_q + CNT_WIDTH'(1);
  end

  fm0_bit_decoder_half_symbol_integrator u_integrator (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (start),
    .en_i         (run_c),
    .dat_i        (in_dat),
    .half_len_i   (half_len_q),
    .level_c      (level_c),
    .half_close_c (half_close_c)
  );

  // Decoder FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      half_len_q  <= '0;
      half_q      <= 1'b0;
      h1_q        <= 1'b0;
      prev_q      <= 1'b0;
      first_sym_q <= 1'b0;
      bits_q      <= '0;
      out_bit     <= 1'b0;
      out_vld     <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_bits  <= '0;
      busy        <= 1'b0;
    end else begin
      out_vld    <= 1'b0;
      frame_done <= 1'b0;

      case (state_q)
        ST_IDLE: begin
        end
        ST_RUN: begin
          if (!start && half_close_c) begin
            if (!half_q) begin
              h1_q   <= level_c;
              half_q <= 1'b1;
            end else begin
              half_q <= 1'b0;
              if (!first_sym_q && !fm0_boundary_ok(prev_q, h1_q)) begin
                // Reported immediately so it occupies the slot of the lost bit.
                frame_done <= 1'b1;
                frame_err  <= 1'b0;
                frame_bits <= bits_q;
                busy       <= 1'b0;
                state_q    <= ST_IDLE;
              end else begin
                out_bit     <= fm0_data_bit(h1_q, level_c);
                out_vld     <= 1'b1;
                prev_q      <= level_c;
                first_sym_q <= 1'b0;
                bits_q      <= bits_d;
                if (bits_d == MAX_CNT) begin
                  state_q <= ST_DONE;
                end
              end
            end
          end
        end
        ST_DONE: begin
          frame_done <= 1'b1;
          frame_err  <= 1'b1;
          frame_bits <= bits_q;
          busy       <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      // Start from any state (re)initialises the frame; overrides the above.
      if (start) begin
        state_q     <= ST_RUN;
        busy        <= 1'b1;
        half_len_q  <= bank_len_c;
        half_q      <= 1'b0;
        first_sym_q <= 1'b1;
        bits_q      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fm0_bit_decoder.sv
// Self-checking bench for fm0_bit_decoder against a half-symbol level model.
module tb_fm0_bit_decoder;

  localparam int unsigned BANKS     = 4;
  localparam int unsigned MAX_BITS  = 4;
  localparam int unsigned CNT_WIDTH = 16;
  localparam int          PAD       = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [1:0]           bank;
  logic                 in_dat;
  logic                 in_vld;
  logic                 out_bit;
  logic                 out_vld;
  logic                 frame_done;
  logic                 frame_err;
  logic [CNT_WIDTH-1:0] frame_bits;
  logic                 busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus slots and expected observations per slot.
  logic s_dat[$];
  logic s_vld[$];
  logic e_vld[$];
  logic e_bit[$];
  logic e_done[$];
  logic e_busy[$];
  int   e_err;
  int   e_nbits;

  // Captured frame results.
  logic got_bits[$];
  int   got_done;
  logic got_err;
  int   got_nbits;

  always #5 clk = ~clk;

  fm0_bit_decoder #(
    .BANKS     (BANKS),
    .HALF_LENS ({8'd20, 8'd16, 8'd12, 8'd8}),
    .MAX_BITS  (MAX_BITS),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bank       (bank),
    .in_dat     (in_dat),
    .in_vld     (in_vld),
    .out_bit    (out_bit),
    .out_vld    (out_vld),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .frame_bits (frame_bits),
    .busy       (busy)
  );

  function automatic int hl_of(input int b);
    case (b)
      0:       return 8;
      1:       return 12;
      2:       return 16;
      default: return 20;
    endcase
  endfunction

  function automatic logic [31:0] pack_got();
    logic [31:0] v;
    v = '0;
    foreach (got_bits[i]) v = {v[30:0], got_bits[i]};
    return v;
  endfunction

  // One half-symbol of hl valid samples with exactly k ones, shuffled.
  task automatic push_count(input int k, input int hl, input int stall_pct);
    logic smp[$];
    int   r;
    logic t;
    for (int i = 0; i < hl; i++) smp.push_back(i < k);
    for (int i = hl - 1; i > 0; i--) begin
      r = int'($urandom_range(i, 0));
      t = smp[i]; smp[i] = smp[r]; smp[r] = t;
    end
    for (int i = 0; i < hl; i++) begin
      if (int'($urandom_range(99, 0)) < stall_pct) begin
        s_dat.push_back(1'($urandom));
        s_vld.push_back(1'b0);
      end
      s_dat.push_back(smp[i]);
      s_vld.push_back(1'b1);
    end
  endtask

  task automatic push_level(input logic lvl, input int hl, input int stall_pct);
    int thr;
    int k;
    thr = (hl + 1) / 2;
    k = lvl ? int'($urandom_range(hl, thr)) : int'($urandom_range(thr - 1, 0));
    push_count(k, hl, stall_pct);
  endtask

  // Valid FM0 symbols carrying data[0..n-1].
  task automatic push_syms(input logic [31:0] data, input int n, input int hl, input int stall_pct);
    logic prev;
    logic h1;
    prev = 1'($urandom);
    for (int i = 0; i < n; i++) begin
      h1 = ~prev;
      push_level(h1, hl, stall_pct);
      push_level(data[i] ? h1 : ~h1, hl, stall_pct);
      prev = data[i] ? h1 : ~h1;
    end
  endtask

  // Reference: chunk valid samples into halves, pair into symbols, apply FM0 rules.
  task automatic model(input int hl);
    int   vidx[$];
    logic vdat[$];
    logic lv[$];
    int   lc[$];
    int   n, sum, nh, end_obs, c;
    logic prev, h1, h2;
    n = int'(s_dat.size()) + PAD;
    e_vld.delete(); e_bit.delete(); e_done.delete(); e_busy.delete();
    for (int j = 0; j < n; j++) begin
      e_vld.push_back(1'b0); e_bit.push_back(1'b0);
      e_done.push_back(1'b0); e_busy.push_back(1'b1);
    end
    for (int j = 0; j < int'(s_dat.size()); j++) begin
      if (s_vld[j]) begin vidx.push_back(j); vdat.push_back(s_dat[j]); end
    end
    nh = int'(vdat.size()) / hl;
    for (int h = 0; h < nh; h++) begin
      sum = 0;
      for (int i = 0; i < hl; i++) sum += int'(vdat[h*hl + i]);
      lv.push_back(2 * sum >= hl);
      lc.push_back(vidx[h*hl + hl - 1]);
    end
    e_err = -1; e_nbits = -1; end_obs = n; prev = 1'b0;
    for (int s = 0; 2*s + 1 < nh; s++) begin
      h1 = lv[2*s]; h2 = lv[2*s + 1]; c = lc[2*s + 1];
      if (s > 0 && h1 == prev) begin
        end_obs = c; e_err = 0; e_nbits = s;
        break;
      end
      e_vld[c] = 1'b1; e_bit[c] = (h1 == h2); prev = h2;
      if (s + 1 == int'(MAX_BITS)) begin
        end_obs = c + 1; e_err = 1; e_nbits = s + 1;
        break;
      end
    end
    for (int j = end_obs; j < n; j++) e_busy[j] = 1'b0;
    if (end_obs < n) e_done[end_obs] = 1'b1;
  endtask

  // Start a frame on bank b, drive the slot queues and check every cycle.
  task automatic run_stream(input int b);
    int n;
    model(hl_of(b));
    n = int'(s_dat.size()) + PAD;
    got_bits.delete(); got_done = 0; got_err = 1'b0; got_nbits = -1;
    @(negedge clk);
    start = 1'b1; bank = 2'(b); in_dat = 1'($urandom); in_vld = 1'($urandom);
    @(negedge clk);
    n_cmp++;
    if ({busy, out_vld, frame_done} !== 3'b100) begin
      n_bad++;
      $display("FAIL start_ack bank %0d: busy/out_vld/frame_done got %b want 100", b, {busy, out_vld, frame_done});
    end
    start = 1'b0;
    for (int j = 0; j < n; j++) begin
      if (j < int'(s_dat.size())) begin in_dat = s_dat[j]; in_vld = s_vld[j]; end
      else begin in_dat = 1'($urandom); in_vld = 1'b0; end
      @(negedge clk);
      n_cmp++;
      if ({out_vld, frame_done, busy} !== {e_vld[j], e_done[j], e_busy[j]}) begin
        n_bad++;
        $display("FAIL slot %0d: out_vld/frame_done/busy got %b want %b", j,
                 {out_vld, frame_done, busy}, {e_vld[j], e_done[j], e_busy[j]});
      end
      if (out_vld === 1'b1) got_bits.push_back(out_bit);
      if (e_vld[j] && out_vld === 1'b1) begin
        n_cmp++;
        if (out_bit !== e_bit[j]) begin
          n_bad++;
          $display("FAIL out_bit slot %0d: got %b want %b", j, out_bit, e_bit[j]);
        end
      end
      if (e_done[j]) begin
        n_cmp++;
        if ({frame_err, frame_bits} !== {1'(e_err), CNT_WIDTH'(e_nbits)}) begin
          n_bad++;
          $display("FAIL frame_end slot %0d: err/bits got %b/%0d want %0d/%0d", j,
                   frame_err, frame_bits, e_err, e_nbits);
        end
      end
      if (frame_done === 1'b1) begin
        got_done++; got_err = frame_err; got_nbits = int'(frame_bits);
      end
    end
    in_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bank = '0; in_dat = 1'b1; in_vld = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({out_bit, out_vld, frame_done, frame_err, frame_bits, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_values: got %b want all zero",
               {out_bit, out_vld, frame_done, frame_err, frame_bits, busy});
    end
    rst = 1'b0; in_vld = 1'b0;
  endtask

  task automatic test_basic();
    logic [5:0] lv;
    lv = 6'b11_01_00;
    s_dat.delete(); s_vld.delete();
    for (int i = 5; i >= 0; i--) push_level(lv[i], 8, 0);
    run_stream(0);
    n_cmp++;
    if (got_bits.size() != 3 || pack_got() !== 32'b101 || got_done != 0) begin
      n_bad++;
      $display("FAIL basic_bits: got %0d bits %b done %0d want 3 bits 101 done 0",
               got_bits.size(), pack_got(), got_done);
    end
  endtask

  task automatic test_violation();
    logic [7:0] lv;
    lv = 8'b11_01_01_11;
    s_dat.delete(); s_vld.delete();
    for (int i = 7; i >= 0; i--) push_level(lv[i], 8, 0);
    run_stream(0);
    n_cmp++;
    if (got_bits.size() != 3 || pack_got() !== 32'b100 || got_done != 1 ||
        got_err !== 1'b0 || got_nbits != 3) begin
      n_bad++;
      $display("FAIL violation_end: got %0d bits %b done %0d err %b nbits %0d want 3 bits 100 done 1 err 0 nbits 3",
               got_bits.size(), pack_got(), got_done, got_err, got_nbits);
    end
  endtask

  task automatic test_threshold();
    int k[6];
    k = '{8, 7, 8, 7, 7, 9};
    s_dat.delete(); s_vld.delete();
    for (int i = 0; i < 6; i++) push_count(k[i], 16, 0);
    run_stream(2);
    n_cmp++;
    if (got_bits.size() != 2 || pack_got() !== 32'b00 || got_done != 1 ||
        got_err !== 1'b0 || got_nbits != 2) begin
      n_bad++;
      $display("FAIL threshold: got %0d bits %b done %0d err %b nbits %0d want 2 bits 00 done 1 err 0 nbits 2",
               got_bits.size(), pack_got(), got_done, got_err, got_nbits);
    end
  endtask

  task automatic test_max_bits();
    logic [31:0] data;
    logic [31:0] want;
    data = $urandom;
    want = {28'd0, data[0], data[1], data[2], data[3]};
    s_dat.delete(); s_vld.delete();
    push_syms(data, 6, 12, 0);
    run_stream(1);
    n_cmp++;
    if (got_bits.size() != 4 || pack_got() !== want || got_done != 1 ||
        got_err !== 1'b1 || got_nbits != 4) begin
      n_bad++;
      $display("FAIL max_bits: got %0d bits %b done %0d err %b nbits %0d want 4 bits %b done 1 err 1 nbits 4",
               got_bits.size(), pack_got(), got_done, got_err, got_nbits, want[3:0]);
    end
  endtask

  task automatic test_stall();
    logic base_d[$];
    logic ref_bits[$];
    logic [31:0] data;
    data = $urandom;
    s_dat.delete(); s_vld.delete();
    push_syms(data, 3, 8, 0);
    base_d = s_dat;
    run_stream(0);
    ref_bits = got_bits;
    s_dat.delete(); s_vld.delete();
    foreach (base_d[i]) begin
      s_dat.push_back(1'($urandom)); s_vld.push_back(1'b0);
      s_dat.push_back(base_d[i]);    s_vld.push_back(1'b1);
    end
    run_stream(0);
    n_cmp++;
    if (got_bits.size() != 3 || got_bits != ref_bits ||
        pack_got() !== {29'd0, data[0], data[1], data[2]}) begin
      n_bad++;
      $display("FAIL stall_equiv: got %0d bits %b want 3 bits %b", got_bits.size(), pack_got(),
               {data[0], data[1], data[2]});
    end
  endtask

  task automatic test_restart();
    logic [3:0] lv;
    s_dat.delete(); s_vld.delete();
    push_syms($urandom, 1, 16, 0);
    push_level(1'($urandom), 16, 0);
    @(negedge clk);
    start = 1'b1; bank = 2'd2; in_vld = 1'b0;
    @(negedge clk);
    start = 1'b0;
    foreach (s_dat[j]) begin
      in_dat = s_dat[j]; in_vld = s_vld[j];
      @(negedge clk);
      n_cmp++;
      if (frame_done !== 1'b0 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL restart_prefix slot %0d: frame_done/busy got %b%b want 01", j, frame_done, busy);
      end
    end
    lv = 4'b11_01;
    s_dat.delete(); s_vld.delete();
    for (int i = 3; i >= 0; i--) push_level(lv[i], 8, 30);
    run_stream(0);
    n_cmp++;
    if (got_bits.size() != 2 || pack_got() !== 32'b10 || got_done != 0) begin
      n_bad++;
      $display("FAIL restart_bits: got %0d bits %b done %0d want 2 bits 10 done 0",
               got_bits.size(), pack_got(), got_done);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] data;
    s_dat.delete(); s_vld.delete();
    push_syms($urandom, 2, 12, 0);
    push_level(1'($urandom), 12, 0);
    run_stream(1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({out_bit, out_vld, frame_done, frame_err, frame_bits, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_midframe: got %b want all zero",
               {out_bit, out_vld, frame_done, frame_err, frame_bits, busy});
    end
    rst = 1'b0;
    for (int j = 0; j < 30; j++) begin
      in_dat = 1'($urandom); in_vld = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({out_vld, frame_done, busy} !== 3'b000) begin
        n_bad++;
        $display("FAIL idle_after_reset cycle %0d: out_vld/frame_done/busy got %b want 000", j,
                 {out_vld, frame_done, busy});
      end
    end
    in_vld = 1'b0;
    data = $urandom;
    s_dat.delete(); s_vld.delete();
    push_syms(data, 3, 20, 20);
    run_stream(3);
    n_cmp++;
    if (got_bits.size() != 3 || pack_got() !== {29'd0, data[0], data[1], data[2]}) begin
      n_bad++;
      $display("FAIL bank3_after_reset: got %0d bits %b want 3 bits %b", got_bits.size(), pack_got(),
               {data[0], data[1], data[2]});
    end
  endtask

  task automatic test_random();
    int b, nh, stall, extra;
    for (int it = 0; it < 10; it++) begin
      b = int'($urandom_range(3, 0));
      nh = int'($urandom_range(12, 2));
      stall = int'($urandom_range(60, 0));
      s_dat.delete(); s_vld.delete();
      for (int h = 0; h < nh; h++) push_level(1'($urandom), hl_of(b), stall);
      extra = int'($urandom_range(5, 0));
      for (int i = 0; i < extra; i++) begin s_dat.push_back(1'($urandom)); s_vld.push_back(1'b1); end
      run_stream(b);
      n_cmp++;
      if (got_done != ((e_nbits >= 0) ? 1 : 0)) begin
        n_bad++;
        $display("FAIL random_done iter %0d: frame_done pulses got %0d want %0d", it, got_done,
                 (e_nbits >= 0) ? 1 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_violation();
    test_threshold();
    test_max_bits();
    test_stall();
    test_restart();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fm0_bit_decoder.md
# fm0_bit_decoder

Downstream of the preamble detector in the tag-to-reader receive chain. Consumes the 1-bit oversampled stream (`in_dat`/`in_vld`) and the selected `frequency_bank`, and integrates each FM0 half-symbol by majority vote. It emits decoded data bits and reports the end of frame when it sees an FM0 violation. The first sample after `start` is the first sample of the first data symbol; the detector's FIFO jump guarantees this alignment.

## Interface
Parameters:
- `BANKS`, 4, number of frequency banks; must match the detector.
- `HALF_LENS`, {8'd20,8'd16,8'd12,8'd8}, packed samples-per-half-symbol. Bank i uses `HALF_LENS[i*8+:8]`. Each value must be ≥2.
- `MAX_BITS`, 512, frame length cap.
- `CNT_WIDTH`, 16, width of `frame_bits`.

Ports:
- `clk`, in, 1, clock.
- `rst`, in, 1, reset: synchronous, active-high; clock `clk`.
- `start`, in, 1, one-cycle pulse; connect to detector `preamble_detected`.
- `bank`, in, $clog2(BANKS), frequency bank; sampled only when `start`=1.
- `in_dat`, in, 1, sample.
- `in_vld`, in, 1, sample strobe.
- `out_bit`, out, 1, decoded bit.
- `out_vld`, out, 1, one-cycle strobe qualifying `out_bit`.
- `frame_done`, out, 1, one-cycle end-of-frame pulse.
- `frame_err`, out, 1, valid with `frame_done`: 1 means the frame was ended by the `MAX_BITS` cap, 0 means it was ended by a violation.
- `frame_bits`, out, `CNT_WIDTH`, number of bits emitted in the frame; valid with `frame_done`, then held.
- `busy`, out, 1, high in RUN.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: samples are ignored.
  - `start` → RUN.
  - On entry to RUN: latch `half_len` from `bank`, clear the accumulator, clear the half-sample counter `hcnt`, set `first_sym`=1, clear `bits`.
- RUN, per `in_vld`:
  - Add `in_dat` to `ones`.
  - Increment `hcnt`.
  - On the sample where `hcnt==half_len-1`: level = (2·ones_incl_current ≥ `half_len`), so a tie resolves to 1. Then reset `ones` and `hcnt`, and toggle the `half` phase.
- Symbol close, at the end of the second half, with h1/h2 = the first/second half levels and `prev` = the previous h2:
  - If `first_sym`=0 and h1==`prev`: violation, i.e. a missing boundary inversion. Go to DONE with `frame_err`=0. No bit is emitted.
  - Otherwise emit `out_bit` = (h1==h2). A mid-symbol inversion is data-0; no inversion is data-1. Then set `prev`=h2, clear `first_sym`, and increment `bits`.
  - If `bits` reaches `MAX_BITS` after emission: go to DONE with `frame_err`=1.
- DONE: pulse `frame_done`, present `frame_bits`=`bits`, return to IDLE next cycle.
- `start` in RUN: abort and restart as if entering from IDLE. No `frame_done` is produced for the aborted frame, and `bank` is re-latched.
- `start` in DONE: `frame_done` still pulses. The next state is RUN with the restart initialisation.
- `in_vld`=0 cycles in RUN are stalls: all counters hold.
- Violation detection covers the second-half close only. h1 is checked against `prev` at the symbol close, not at the half close.
- Width rules:
  - `hcnt` and `ones` are 8 bits.
  - `bits` is `CNT_WIDTH` bits and saturates at `MAX_BITS`.
  - `2·ones` is computed at 9 bits.

## Timing
- Reset values: `out_bit`=0, `out_vld`=0, `frame_done`=0, `frame_err`=0, `frame_bits`=0, `busy`=0; state IDLE.
- `out_vld`/`out_bit` are registered and assert the cycle after the `in_vld` sample that closes a symbol.
- `frame_done` asserts in the cycle after the closing sample:
  - For a violation close, that is the same cycle slot where `out_vld` would have been.
  - For a `MAX_BITS` close, it is one cycle after the final `out_vld`.
- `busy` rises the cycle after `start` and falls the cycle `frame_done` asserts.
- Maximum throughput is one sample per cycle. No backpressure; the consumer must accept every `out_vld`.
- `rst` mid-frame: return to IDLE next edge with all outputs at reset values. No `frame_done`.

## Structure
- Shared header `rfid_defs.vh` holds:
  - the FSM encodings (IDLE/RUN/DONE);
  - the default `HALF_LENS` packing;
  - the FM0 symbol conventions, which are also used by the transmit encoder.
- Sub-module `half_symbol_integrator` holds `hcnt`, `ones` and the majority decision. It outputs `level` and a `half_close` strobe, and is cleared by `start`.

## Test plan
- Bank 0 (`half_len`=8), `start`, then halves 1,1 | 0,1 | 0,0 → `out_bit` 1, 0, 1 on three `out_vld` pulses.
- Same setup, then two equal halves 1,1 following a symbol that ended in level 1 → `frame_done`=1, `frame_err`=0, `frame_bits`=3; no 4th `out_vld`.
- Bank 2 (`half_len`=16), 7/16 ones in a half → level 0; 8/16 ones → level 1.
- `MAX_BITS`=4, valid alternating stream → 4 `out_vld`, then `frame_done` with `frame_err`=1 and `frame_bits`=4.
- Stream with `in_vld` toggling 0/1 every cycle → identical bit sequence as the same samples delivered contiguously.
- `rst` asserted after the 2nd bit of a frame → all outputs 0 next cycle, no `frame_done`. Then a `start` with bank 3 → `half_len`=20 is used.
